// File: rtl/credit_receiver_fifo_pkg.sv
// Width helpers shared by the credit receiver FIFO and its lane-offset unit.
// Counters use the same $clog2 + 1 rule as the sender's credit counter.
package credit_receiver_fifo_pkg;

  function automatic int unsigned cnt_width(input int unsigned depth);
    return $clog2(depth) + 1;
  endfunction

  function automatic int unsigned ptr_width(input int unsigned depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

endpackage

// File: rtl/credit_receiver_fifo_push_lane_offsets.sv
// Per-lane prefix counts for a multi-issue push, clamped to the free slots.
// A set lane is written only if the lanes below it leave room for it.
module push_lane_offsets #(
  parameter int unsigned NumPush  = 1,
  parameter int unsigned CntWidth = 2
) (
  input  logic [NumPush-1:0]               valid_i,
  input  logic [CntWidth-1:0]              free_i,
  output logic [NumPush-1:0][CntWidth-1:0] offset_o,
  output logic [NumPush-1:0]               write_o,
  output logic [CntWidth-1:0]              n_push_o
);

  logic [CntWidth-1:0] running;

  // NOTE: every output gets a default before the loop so no latch is inferred;
  // blocking assignments are required here because running is a loop accumulator.
  always_comb begin
    running  = '0;
    offset_o = '0;
    write_o  = '0;
    for (int i = 0; i < NumPush; i++) begin
      offset_o[i] = running;
      write_o[i]  = valid_i[i] && (running < free_i);
      running     = running + CntWidth'(valid_i[i]);
    end
    n_push_o = (running > free_i) ? free_i : running;
  end

endmodule

// File: rtl/credit_receiver_fifo.sv
// Consumer-side FIFO of a credit loop: multi-lane push, single pop, one credit per pop.
// Define CREDIT_RECEIVER_OVERFLOW_CHECK_EN to build the sticky overflow flag and checks.
module credit_receiver_fifo
  import credit_receiver_fifo_pkg::*;
#(
  parameter int unsigned NumPush  = 1,
  parameter int unsigned Depth    = 4,
  parameter type         data_t   = logic [31:0],
  localparam int unsigned CntWidth = cnt_width(Depth)
) (
  input  logic                      clk_i,
  input  logic                      rst_ni,
  input  logic                      flush_i,
  input  logic [NumPush-1:0]        push_valid_i,
  input  data_t [NumPush-1:0]       push_data_i,
  output logic                      out_valid_o,
  input  logic                      out_ready_i,
  output data_t                     out_data_o,
  output logic                      credit_give_o,
  output logic [CntWidth-1:0]       fill_o,
  output logic                      overflow_o
);

  localparam int unsigned PtrWidth = ptr_width(Depth);

  logic [CntWidth-1:0]              fill_q;
  logic [PtrWidth-1:0]              wr_ptr_q;
  logic [PtrWidth-1:0]              rd_ptr_q;
  logic                             credit_q;
  data_t                            mem [Depth];

  logic [CntWidth-1:0]              free;
  logic [NumPush-1:0][CntWidth-1:0] offset;
  logic [NumPush-1:0]               write;
  logic [CntWidth-1:0]              n_push;
  logic [NumPush-1:0][PtrWidth-1:0] slot;
  logic                             pop;

  // Modular add for pointers; both operands are below Depth so one subtract suffices.
  function automatic logic [PtrWidth-1:0] wrap_add(input logic [PtrWidth-1:0] ptr,
                                                   input logic [CntWidth-1:0] inc);
    logic [CntWidth:0] sum;
    sum = (CntWidth+1)'(ptr) + (CntWidth+1)'(inc);
    if (sum >= (CntWidth+1)'(Depth)) sum = sum - (CntWidth+1)'(Depth);
    return PtrWidth'(sum);
  endfunction

  // Legality is judged against pre-pop occupancy: a freed slot is not reusable until its credit returns.
  assign free = CntWidth'(Depth) - fill_q;

  push_lane_offsets #(
    .NumPush  (NumPush),
    .CntWidth (CntWidth)
  ) u_offsets (
    .valid_i  (push_valid_i),
    .free_i   (free),
    .offset_o (offset),
    .write_o  (write),
    .n_push_o (n_push)
  );

  always_comb begin
    for (int i = 0; i < NumPush; i++) begin
      slot[i] = wrap_add(wr_ptr_q, offset[i]);
    end
  end

  assign out_valid_o   = (fill_q != '0);
  assign out_data_o    = mem[rd_ptr_q];
  assign pop           = out_valid_o && out_ready_i;
  assign credit_give_o = credit_q;
  assign fill_o        = fill_q;

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      fill_q   <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      credit_q <= 1'b0;
    end else if (flush_i) begin
      fill_q   <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      credit_q <= 1'b0;
    end else begin
      fill_q   <= fill_q + n_push - CntWidth'(pop);
      wr_ptr_q <= wrap_add(wr_ptr_q, n_push);
      if (pop) rd_ptr_q <= wrap_add(rd_ptr_q, CntWidth'(1));
      credit_q <= pop;
    end
  end

  // NOTE: the storage array is deliberately not reset; only control state is, and
  // out_valid_o masks any stale contents.
  always_ff @(posedge clk_i) begin
    if (!flush_i) begin
      for (int i = 0; i < NumPush; i++) begin
        if (write[i]) mem[slot[i]] <= push_data_i[i];
      end
    end
  end

`ifdef CREDIT_RECEIVER_OVERFLOW_CHECK_EN
  logic overflow_q;
  logic push_drop;

  assign push_drop = |(push_valid_i & ~write);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni)        overflow_q <= 1'b0;
    else if (flush_i)   overflow_q <= 1'b0;
    else if (push_drop) overflow_q <= 1'b1;
  end

  assign overflow_o = overflow_q;

  illegal_push_a : assert property (@(posedge clk_i) disable iff (!rst_ni) !(push_drop && !flush_i));
  empty_pop_a    : assert property (@(posedge clk_i) disable iff (!rst_ni) !(pop && fill_q == '0));
`else
  assign overflow_o = 1'b0;
`endif

endmodule

// File: tb/tb_credit_receiver_fifo.sv
// Bench for credit_receiver_fifo: a Depth=4 and a Depth=3 instance, each checked every
// cycle against a queue model, plus directed scenarios with literal expectations.
module tb_credit_receiver_fifo;

`ifdef CREDIT_RECEIVER_OVERFLOW_CHECK_EN
  localparam bit OvfEn = 1'b1;
`else
  localparam bit OvfEn = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic [1:0]       pv  [2];
  logic [1:0][31:0] pd  [2];
  logic             rdy [2];
  logic             fl  [2];
  logic             ov  [2];
  logic [31:0]      od  [2];
  logic             cg  [2];
  logic [2:0]       fi  [2];
  logic             of  [2];

  credit_receiver_fifo #(.NumPush(2), .Depth(4)) dut4 (
    .clk_i (clk), .rst_ni (rst_n), .flush_i (fl[0]),
    .push_valid_i (pv[0]), .push_data_i (pd[0]),
    .out_valid_o (ov[0]), .out_ready_i (rdy[0]), .out_data_o (od[0]),
    .credit_give_o (cg[0]), .fill_o (fi[0]), .overflow_o (of[0])
  );

  credit_receiver_fifo #(.NumPush(2), .Depth(3)) dut3 (
    .clk_i (clk), .rst_ni (rst_n), .flush_i (fl[1]),
    .push_valid_i (pv[1]), .push_data_i (pd[1]),
    .out_valid_o (ov[1]), .out_ready_i (rdy[1]), .out_data_o (od[1]),
    .credit_give_o (cg[1]), .fill_o (fi[1]), .overflow_o (of[1])
  );

  // Reference model: a queue of accepted entries plus expected credit and overflow bits.
  logic [31:0] mq [2][$];
  bit          exp_cg [2];
  bit          exp_of [2];
  int          compared   = 0;
  int          mismatched = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  function automatic int depth_of(input int k);
    return (k == 0) ? 4 : 3;
  endfunction

  task automatic model_clear();
    for (int k = 0; k < 2; k++) begin
      mq[k].delete();
      exp_cg[k] = 1'b0;
      exp_of[k] = 1'b0;
    end
  endtask

  task automatic model_step(input int k);
    bit pop;
    if (fl[k]) begin
      mq[k].delete();
      exp_cg[k] = 1'b0;
      exp_of[k] = 1'b0;
    end else begin
      pop = (mq[k].size() != 0) && rdy[k];
      for (int i = 0; i < 2; i++) begin
        if (pv[k][i]) begin
          if (mq[k].size() < depth_of(k)) mq[k].push_back(pd[k][i]);
          else if (OvfEn) exp_of[k] = 1'b1;
        end
      end
      if (pop) void'(mq[k].pop_front());
      exp_cg[k] = pop;
    end
  endtask

  task automatic compare_all();
    for (int k = 0; k < 2; k++) begin
      check($sformatf("d%0d.out_valid", k), 32'(ov[k]), 32'(mq[k].size() != 0));
      if (mq[k].size() != 0) check($sformatf("d%0d.out_data", k), od[k], mq[k][0]);
      check($sformatf("d%0d.fill", k), 32'(fi[k]), 32'(mq[k].size()));
      check($sformatf("d%0d.credit", k), 32'(cg[k]), 32'(exp_cg[k]));
      check($sformatf("d%0d.overflow", k), 32'(of[k]), 32'(exp_of[k]));
    end
  endtask

  // Inputs are set at the negedge, applied at the posedge, outputs compared at the next negedge.
  task automatic cycle();
    @(posedge clk);
    for (int k = 0; k < 2; k++) model_step(k);
    @(negedge clk);
    compare_all();
  endtask

  task automatic idle();
    for (int k = 0; k < 2; k++) begin
      pv[k]  = '0;
      pd[k]  = '0;
      rdy[k] = 1'b0;
      fl[k]  = 1'b0;
    end
  endtask

  localparam logic [31:0] A = 32'hAAAA_0001;
  localparam logic [31:0] B = 32'hBBBB_0002;
  localparam logic [31:0] C = 32'hCCCC_0003;
  localparam logic [31:0] X = 32'hDEAD_0004;

  initial begin
    logic [31:0] order [3];
    order[0] = A; order[1] = B; order[2] = C;
    idle();
    model_clear();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    for (int k = 0; k < 2; k++) begin
      check("reset.out_valid", 32'(ov[k]), 32'd0);
      check("reset.credit", 32'(cg[k]), 32'd0);
      check("reset.fill", 32'(fi[k]), 32'd0);
      check("reset.overflow", 32'(of[k]), 32'd0);
    end

    // Two lanes at once, ready low: head is A one cycle later.
    pv[0] = 2'b11; pd[0][0] = A; pd[0][1] = B;
    cycle();
    check("t1.out_valid", 32'(ov[0]), 32'd1);
    check("t1.out_data", od[0], A);
    check("t1.fill", 32'(fi[0]), 32'd2);

    // Only lane 1 set: C queues behind B, X is ignored.
    pv[0] = 2'b10; pd[0][0] = X; pd[0][1] = C;
    cycle();
    check("t2.fill", 32'(fi[0]), 32'd3);
    pv[0] = 2'b00; rdy[0] = 1'b1;
    for (int j = 0; j < 3; j++) begin
      check($sformatf("t2.order%0d", j), od[0], order[j]);
      cycle();
      check($sformatf("t2.credit%0d", j), 32'(cg[0]), 32'd1);
    end
    rdy[0] = 1'b0;
    cycle();
    check("t2.credit_after", 32'(cg[0]), 32'd0);
    check("t2.fill_empty", 32'(fi[0]), 32'd0);

    // Depth 3 full, pop and push in the same cycle: the push is dropped.
    pv[1] = 2'b11; pd[1][0] = 32'h10; pd[1][1] = 32'h11;
    cycle();
    pv[1] = 2'b01; pd[1][0] = 32'h12;
    cycle();
    check("t3.full", 32'(fi[1]), 32'd3);
    pv[1] = 2'b01; pd[1][0] = 32'h13; rdy[1] = 1'b1;
    cycle();
    check("t3.fill_after_drop", 32'(fi[1]), 32'd2);
    check("t3.overflow", 32'(of[1]), 32'(OvfEn));
    check("t3.head", od[1], 32'h11);
    idle(); fl[1] = 1'b1;
    cycle();
    check("t3.flush_fill", 32'(fi[1]), 32'd0);
    check("t3.flush_overflow", 32'(of[1]), 32'd0);
    idle();

    // Seven wraps of the Depth 3 pointers with one push and one pop per cycle.
    for (int j = 0; j < 21; j++) begin
      pv[1] = 2'b01; pd[1][0] = 32'h100 + 32'(j); rdy[1] = 1'b1;
      cycle();
    end
    pv[1] = 2'b00;
    cycle();
    check("t4.fill_zero", 32'(fi[1]), 32'd0);
    idle();

    // Pop, then flush with a would-be pop: no credit for the flushed cycle.
    pv[0] = 2'b11; pd[0][0] = 32'h21; pd[0][1] = 32'h22;
    cycle();
    pv[0] = 2'b00; rdy[0] = 1'b1;
    cycle();
    check("t5.credit_pop", 32'(cg[0]), 32'd1);
    fl[0] = 1'b1;
    cycle();
    check("t5.credit_flush", 32'(cg[0]), 32'd0);
    check("t5.fill_flush", 32'(fi[0]), 32'd0);
    check("t5.valid_flush", 32'(ov[0]), 32'd0);
    idle();
    cycle();

    // Mid-stream reset with Depth 3 full and a credit pending on Depth 4.
    pv[0] = 2'b01; pd[0][0] = 32'h31;
    pv[1] = 2'b11; pd[1][0] = 32'h41; pd[1][1] = 32'h42;
    cycle();
    pv[0] = 2'b00; rdy[0] = 1'b1;
    pv[1] = 2'b01; pd[1][0] = 32'h43;
    cycle();
    check("t6.full", 32'(fi[1]), 32'd3);
    check("t6.pending_credit", 32'(cg[0]), 32'd1);
    idle();
    #2 rst_n = 1'b0;
    #1;
    model_clear();
    for (int k = 0; k < 2; k++) begin
      check("t6.rst_valid", 32'(ov[k]), 32'd0);
      check("t6.rst_credit", 32'(cg[k]), 32'd0);
      check("t6.rst_fill", 32'(fi[k]), 32'd0);
      check("t6.rst_overflow", 32'(of[k]), 32'd0);
    end
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    rdy[1] = 1'b1;
    cycle();
    check("t6.no_credit", 32'(cg[1]), 32'd0);
    pv[1] = 2'b01; pd[1][0] = 32'h51;
    cycle();
    pv[1] = 2'b00;
    cycle();
    check("t6.first_credit", 32'(cg[1]), 32'd1);
    idle();
    cycle();

    // Randomized traffic on both instances, including illegal pushes and flushes.
    for (int j = 0; j < 400; j++) begin
      for (int k = 0; k < 2; k++) begin
        pv[k]    = 2'($urandom_range(0, 3));
        pd[k][0] = $urandom;
        pd[k][1] = $urandom;
        rdy[k]   = ($urandom_range(0, 3) != 0);
        fl[k]    = ($urandom_range(0, 31) == 0);
      end
      cycle();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
